// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-stage hazard bus: pipeline observations in, register enables/flushes and event counters out.
// The master drives the pipeline observations and the slave is the hazard controller.
interface pipeline_hazard_ctrl_if;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 16;

    logic [XLEN-1:0]  INSTR_ID;
    logic             STALLSIG_EX;
    logic [REG_W-1:0] RD_EX;
    logic             REDIRECT_EX;
    logic             MEM_BUSY;
    logic             PC_EN;
    logic             IFID_EN;
    logic             IDEX_EN;
    logic             IFID_FLUSH;
    logic             IDEX_FLUSH;
    logic [CNT_W-1:0] STALL_CNT;
    logic [CNT_W-1:0] FLUSH_CNT;
    logic [CNT_W-1:0] HOLD_CNT;
    logic [1:0]       HAZ_STATE;

    modport master (
        output INSTR_ID, STALLSIG_EX, RD_EX, REDIRECT_EX, MEM_BUSY,
        input  PC_EN, IFID_EN, IDEX_EN, IFID_FLUSH, IDEX_FLUSH,
        input  STALL_CNT, FLUSH_CNT, HOLD_CNT, HAZ_STATE
    );

    modport slave (
        input  INSTR_ID, STALLSIG_EX, RD_EX, REDIRECT_EX, MEM_BUSY,
        output PC_EN, IFID_EN, IDEX_EN, IFID_FLUSH, IDEX_FLUSH,
        output STALL_CNT, FLUSH_CNT, HOLD_CNT, HAZ_STATE
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch redirect flush and memory-busy freeze,
// with saturating event counters.
module pipeline_hazard_ctrl (
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_hazard_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OPC_W   = 7;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        HOLD    = 2'b10
    } haz_state_t;

    haz_state_t       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, hold_cnt;
    logic             inc_stall, inc_flush, inc_hold;
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs1, rs2;
    logic             use_rs1, use_rs2, load_use;
    logic             unused_instr_bits;

    // Register-source usage decode
    assign opcode            = bus.INSTR_ID[6:0];
    assign rs1               = bus.INSTR_ID[19:15];
    assign rs2               = bus.INSTR_ID[24:20];
    assign unused_instr_bits = ^{bus.INSTR_ID[31:25], bus.INSTR_ID[14:7]};

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use = bus.STALLSIG_EX && (bus.RD_EX != REG_W'(0)) &&
                      ((use_rs1 && (bus.RD_EX == rs1)) || (use_rs2 && (bus.RD_EX == rs2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Priority MEM_BUSY > REDIRECT_EX > LOAD_USE; a load gets exactly one bubble
    always_comb begin
        state_d        = RUN;
        bus.PC_EN      = 1'b1;
        bus.IFID_EN    = 1'b1;
        bus.IDEX_EN    = 1'b1;
        bus.IFID_FLUSH = 1'b0;
        bus.IDEX_FLUSH = 1'b0;
        inc_stall      = 1'b0;
        inc_flush      = 1'b0;
        inc_hold       = 1'b0;
        if (!rst_n) begin
            bus.PC_EN      = 1'b0;
            bus.IFID_EN    = 1'b0;
            bus.IDEX_EN    = 1'b0;
            bus.IFID_FLUSH = 1'b1;
            bus.IDEX_FLUSH = 1'b1;
        end else if (bus.MEM_BUSY) begin
            bus.PC_EN   = 1'b0;
            bus.IFID_EN = 1'b0;
            bus.IDEX_EN = 1'b0;
            state_d     = HOLD;
            inc_hold    = 1'b1;
        end else if (bus.REDIRECT_EX) begin
            bus.IFID_FLUSH = 1'b1;
            bus.IDEX_FLUSH = 1'b1;
            inc_flush      = 1'b1;
        end else if (load_use && (state_q != LDSTALL)) begin
            bus.PC_EN      = 1'b0;
            bus.IFID_EN    = 1'b0;
            bus.IDEX_FLUSH = 1'b1;
            state_d        = LDSTALL;
            inc_stall      = 1'b1;
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            if (inc_stall && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (inc_flush && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + CNT_W'(1);
            if (inc_hold  && (hold_cnt  != CNT_MAX)) hold_cnt  <= hold_cnt  + CNT_W'(1);
        end
    end

    assign bus.STALL_CNT = stall_cnt;
    assign bus.FLUSH_CNT = flush_cnt;
    assign bus.HOLD_CNT  = hold_cnt;
    assign bus.HAZ_STATE = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed and randomized bench for pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus ();
    pipeline_hazard_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Model: counts plus "just inserted a load bubble" and "memory frozen last cycle" flags
    int m_stall, m_flush, m_hold;
    bit m_bubble, m_frozen;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit reads_rs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic [47:0] model_cnts();
        return {16'(m_stall), 16'(m_flush), 16'(m_hold)};
    endfunction

    function automatic logic [1:0] model_state();
        if (m_bubble) return 2'b01;
        if (m_frozen) return 2'b10;
        return 2'b00;
    endfunction

    // Asynchronous reset applied mid-cycle; outputs must react before any clock edge
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        m_stall = 0; m_flush = 0; m_hold = 0;
        m_bubble = 0; m_frozen = 0;
        check("rst_ctl", 64'({bus.PC_EN, bus.IFID_EN, bus.IDEX_EN, bus.IFID_FLUSH, bus.IDEX_FLUSH}), 64'(5'b00011));
        check("rst_cnt", 64'({bus.STALL_CNT, bus.FLUSH_CNT, bus.HOLD_CNT}), 64'(48'd0));
        check("rst_state", 64'(bus.HAZ_STATE), 64'(2'b00));
        @(posedge clk);
        #1;
        check("rst_hold_cnt", 64'({bus.STALL_CNT, bus.FLUSH_CNT, bus.HOLD_CNT}), 64'(48'd0));
        rst_n = 1'b1;
    endtask

    // One cycle: drive inputs, check zero-latency controls, clock, check state and counters
    task automatic step(input logic [31:0] instr, input logic ss, input logic [4:0] rd,
                        input logic redir, input logic mb);
        logic [4:0] exp_ctl;
        bit lu;
        bus.INSTR_ID    = instr;
        bus.STALLSIG_EX = ss;
        bus.RD_EX       = rd;
        bus.REDIRECT_EX = redir;
        bus.MEM_BUSY    = mb;
        #1;
        lu = ss && (rd != 0) && ((reads_rs1(instr[6:0]) && rd == instr[19:15]) ||
                                 (reads_rs2(instr[6:0]) && rd == instr[24:20]));
        if (mb) begin
            exp_ctl = 5'b00000;
            m_hold = (m_hold < 65535) ? m_hold + 1 : m_hold;
            m_frozen = 1; m_bubble = 0;
        end else if (redir) begin
            exp_ctl = 5'b11111;
            m_flush = (m_flush < 65535) ? m_flush + 1 : m_flush;
            m_frozen = 0; m_bubble = 0;
        end else if (lu && !m_bubble) begin
            exp_ctl = 5'b00101;
            m_stall = (m_stall < 65535) ? m_stall + 1 : m_stall;
            m_frozen = 0; m_bubble = 1;
        end else begin
            exp_ctl = 5'b11100;
            m_frozen = 0; m_bubble = 0;
        end
        check("ctl", 64'({bus.PC_EN, bus.IFID_EN, bus.IDEX_EN, bus.IFID_FLUSH, bus.IDEX_FLUSH}), 64'(exp_ctl));
        @(posedge clk);
        #1;
        check("state", 64'(bus.HAZ_STATE), 64'(model_state()));
        check("cnt", 64'({bus.STALL_CNT, bus.FLUSH_CNT, bus.HOLD_CNT}), 64'(model_cnts()));
    endtask

    localparam logic [31:0] ADD_X6_X5_X7 = 32'h0072_8333;
    localparam logic [31:0] ADDI_X0      = 32'h0000_0013;
    localparam logic [31:0] LUI_RS_HIT   = 32'h0052_82B7;

    initial begin
        logic [6:0] ops [8];
        logic [31:0] instr;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111};
        rst_n = 1'b1;
        bus.INSTR_ID = '0; bus.STALLSIG_EX = 0; bus.RD_EX = '0;
        bus.REDIRECT_EX = 0; bus.MEM_BUSY = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Load-use: one bubble, then resume
        step(ADD_X6_X5_X7, 1, 5'd5, 0, 0);
        check("lu_stall_cnt", 64'(bus.STALL_CNT), 64'd1);
        check("lu_state", 64'(bus.HAZ_STATE), 64'(2'b01));
        step(ADD_X6_X5_X7, 1, 5'd5, 0, 0);
        check("lu_resume", 64'(bus.HAZ_STATE), 64'(2'b00));

        // No stall for x0 destination or an instruction without register sources
        step(ADDI_X0, 1, 5'd0, 0, 0);
        step(LUI_RS_HIT, 1, 5'd5, 0, 0);
        check("nolu_stall_cnt", 64'(bus.STALL_CNT), 64'd1);

        // Redirect beats load-use
        do_reset();
        step(ADD_X6_X5_X7, 1, 5'd5, 1, 0);
        check("redir_flush_cnt", 64'(bus.FLUSH_CNT), 64'd1);
        check("redir_stall_cnt", 64'(bus.STALL_CNT), 64'd0);

        // Memory freeze with pending redirect, then redirect acted on once
        do_reset();
        repeat (3) step(ADD_X6_X5_X7, 1, 5'd5, 1, 1);
        check("busy_hold_cnt", 64'(bus.HOLD_CNT), 64'd3);
        check("busy_flush_cnt", 64'(bus.FLUSH_CNT), 64'd0);
        step(ADD_X6_X5_X7, 1, 5'd5, 1, 0);
        check("busy_flush_after", 64'(bus.FLUSH_CNT), 64'd1);

        // Reset while frozen abandons the hold
        step(ADDI_X0, 0, 5'd0, 0, 1);
        check("hold_state", 64'(bus.HAZ_STATE), 64'(2'b10));
        do_reset();
        step(ADDI_X0, 0, 5'd0, 0, 0);

        // Randomized traffic with small register numbers to provoke matches
        for (int i = 0; i < 600; i++) begin
            instr = $urandom();
            instr[6:0]   = ops[$urandom_range(7, 0)];
            instr[19:15] = 5'($urandom_range(3, 0));
            instr[24:20] = 5'($urandom_range(3, 0));
            step(instr, 1'($urandom_range(1, 0)), 5'($urandom_range(3, 0)),
                 ($urandom_range(9, 0) == 0), ($urandom_range(7, 0) == 0));
            if ($urandom_range(99, 0) == 0) do_reset();
        end

        // Stall counter saturation from a preloaded value
        do_reset();
        force dut.stall_cnt = 16'hFFFD;
        #1;
        release dut.stall_cnt;
        m_stall = 65533;
        repeat (4) begin
            step(ADD_X6_X5_X7, 1, 5'd5, 0, 0);
            step(ADDI_X0, 0, 5'd0, 0, 0);
        end
        check("stall_sat", 64'(bus.STALL_CNT), 64'(16'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
